// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared types and helpers for the CORDIC output stage.
//   - CORDIC_DATA_WIDTH : magnitude bits; every data bus is CORDIC_DATA_WIDTH+1 signed.
//   - quarter_t         : quadrant index produced by the chain's angle reduction.
//   - data_t            : signed chain/result sample.
//   - quarter_fixup()   : maps chain (x, y, quarter) back to full-circle {cos, sin}.
//   - quarter_fixup_sat(): reports whether that mapping negated the most negative value.
// Optional feature macro: CORDIC_FIXUP_SAT_EN (saturating negation).
package cordic_pkg;

  localparam int CORDIC_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

  typedef logic signed [CORDIC_DATA_WIDTH:0] data_t;

  typedef struct packed {
    data_t cos_v;
    data_t sin_v;
  } cs_pair_t;

  // -2^DW: the only value whose two's complement negation does not fit.
  localparam data_t DATA_MIN = {1'b1, {CORDIC_DATA_WIDTH{1'b0}}};

  function automatic logic needs_sat(input data_t v);
    return (v == DATA_MIN);
  endfunction

  // Negation without width growth; -2^DW either clamps to +2^DW-1 or wraps to itself.
  function automatic data_t data_neg(input data_t v);
    data_t r;
`ifdef CORDIC_FIXUP_SAT_EN
    if (needs_sat(v)) begin
      r = {1'b0, {CORDIC_DATA_WIDTH{1'b1}}};
    end else begin
      r = -v;
    end
`else
    r = -v;
`endif
    return r;
  endfunction

  function automatic cs_pair_t quarter_fixup(input data_t x, input data_t y, input quarter_t q);
    cs_pair_t r;
    case (q)
      Q0: begin r.cos_v = x;           r.sin_v = y;           end
      Q1: begin r.cos_v = data_neg(y); r.sin_v = x;           end
      Q2: begin r.cos_v = data_neg(x); r.sin_v = data_neg(y); end
      Q3: begin r.cos_v = y;           r.sin_v = data_neg(x); end
      default: begin r.cos_v = x;      r.sin_v = y;           end
    endcase
    return r;
  endfunction

  function automatic logic quarter_fixup_sat(input data_t x, input data_t y, input quarter_t q);
    logic r;
    case (q)
      Q1:      r = needs_sat(y);
      Q2:      r = needs_sat(x) | needs_sat(y);
      Q3:      r = needs_sat(x);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_fixup_checker.sv
// cordic_fixup_checker
// Protocol checks for cordic_quarter_fixup (simulation only; no logic).
//   clock, reset      : block clock and synchronous active-high reset
//   issue_valid/ready : front-end issue handshake
//   push, fifo_full   : result FIFO write strobe and full status
module cordic_fixup_checker (
  input logic clock,
  input logic reset,
  input logic issue_valid,
  input logic issue_ready,
  input logic push,
  input logic fifo_full
);

  // Credit scheme must make a push into a full FIFO impossible; an issue without credit is dropped.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(push && fifo_full))
        else $error("cordic_quarter_fixup: push into full result FIFO");
      assert (!(issue_valid && !issue_ready))
        else $warning("cordic_quarter_fixup: issue_valid without credit, issue dropped");
    end
  end

endmodule

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo
// First-word-fall-through FIFO with a registered head, so the output data
// holds its last value when the FIFO drains empty.
//   WIDTH, DEPTH (power of two, >=2)
//   push/push_data : write; ignored when full
//   pop            : consume head; ignored when empty
//   rd_data        : head entry (valid while !empty)
//   full, empty, count
module cordic_result_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_push;
  logic             w_pop;
  logic             w_head_from_push;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_push = push & (r_count != FULL_COUNT);
  assign w_pop  = pop & r_valid;
  // Nothing older remains after this cycle's pop, so a pushed word becomes the head directly.
  assign w_head_from_push = (r_count == CW'(0)) | ((r_count == CW'(1)) & w_pop);

  // Next count, read pointer and head word.
  always_comb begin
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd_ptr;
    w_head_nxt  = r_head;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
    if (w_pop) begin
      w_rd_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_nxt = r_rd_ptr;
    end
    if (w_count_nxt == CW'(0)) begin
      w_head_nxt = r_head;
    end else if (w_head_from_push) begin
      w_head_nxt = push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_head   <= {WIDTH{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != CW'(0));
    end
  end

  assign rd_data = r_head;
  assign full    = (r_count == FULL_COUNT);
  assign empty   = ~r_valid;
  assign count   = r_count;

endmodule

// File: rtl/cordic_quarter_fixup.sv
// cordic_quarter_fixup
// Output stage behind the CORDIC rotator chain: tracks in-flight samples with
// a valid delay line, undoes the quarter reduction in one registered stage,
// buffers results in a FWFT FIFO and issues credits so the chain never overruns.
// Parameters: DATA_WIDTH (must equal cordic_pkg::CORDIC_DATA_WIDTH),
//             CHAIN_LATENCY (>=2), FIFO_DEPTH (power of two, >=2).
// Ports:
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   issue_valid/issue_ready  : angle issue into the chain, gated by free credit
//   chain_x/chain_y/chain_q  : chain outputs, valid CHAIN_LATENCY cycles after issue
//   out_valid/out_ready      : result handshake
//   out_cos/out_sin          : signed results
//   sat_flag                 : sticky saturating-negation flag
// Optional feature macro: CORDIC_FIXUP_SAT_EN (saturating negation + sat_flag).
module cordic_quarter_fixup
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH    = CORDIC_DATA_WIDTH,
  parameter int CHAIN_LATENCY = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic signed [DATA_WIDTH:0]   chain_x,
  input  logic signed [DATA_WIDTH:0]   chain_y,
  input  logic [1:0]                   chain_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH:0]   out_cos,
  output logic signed [DATA_WIDTH:0]   out_sin,
  output logic                         sat_flag
);

  localparam int DW1 = DATA_WIDTH + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = CW + 1;

  logic [CHAIN_LATENCY-1:0]   r_dly;
  logic                       r_fix_vld;
  logic signed [DATA_WIDTH:0] r_fix_cos;
  logic signed [DATA_WIDTH:0] r_fix_sin;
  logic [CW-1:0]              r_inflight;

  logic                       w_issue_acc;
  logic                       w_cap_en;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [CW-1:0]              w_fifo_count;
  logic [SW-1:0]              w_credit_used;
  logic [2*DW1-1:0]           w_head;
  cs_pair_t                   w_fix;

  // Credits are consumed by everything issued but not yet popped; a pop frees its credit next cycle.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign issue_ready   = (w_credit_used < SW'(FIFO_DEPTH));
  assign w_issue_acc   = issue_valid & issue_ready;
  assign w_cap_en      = r_dly[CHAIN_LATENCY-1];
  assign w_push        = r_fix_vld;
  assign w_pop         = out_valid & out_ready;
  assign w_fix         = quarter_fixup(chain_x, chain_y, quarter_t'(chain_q));

  // Valid delay line mirroring the chain; its tail coincides with the sample on chain_x/y/q.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dly <= {CHAIN_LATENCY{1'b0}};
    end else begin
      r_dly <= {r_dly[CHAIN_LATENCY-2:0], w_issue_acc};
    end
  end

  // Fix-up register: captures the full-circle result when the delay-line tail is set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fix_vld <= 1'b0;
      r_fix_cos <= {DW1{1'b0}};
      r_fix_sin <= {DW1{1'b0}};
    end else begin
      r_fix_vld <= w_cap_en;
      if (w_cap_en) begin
        r_fix_cos <= w_fix.cos_v;
        r_fix_sin <= w_fix.sin_v;
      end
    end
  end

  // In-flight count: issues accepted but not yet pushed into the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= CW'(0);
    end else begin
      case ({w_issue_acc, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifdef CORDIC_FIXUP_SAT_EN
  logic r_sat;

  // Sticky flag: set in the fix-up cycle that clamped a negation, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_cap_en && quarter_fixup_sat(chain_x, chain_y, quarter_t'(chain_q))) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

  cordic_result_fifo #(
    .WIDTH (2 * DW1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data ({r_fix_cos, r_fix_sin}),
    .pop       (w_pop),
    .rd_data   (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign out_valid = ~w_fifo_empty;
  assign out_cos   = w_head[2*DW1-1:DW1];
  assign out_sin   = w_head[DW1-1:0];

  cordic_fixup_checker u_chk (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .push        (w_push),
    .fifo_full   (w_fifo_full)
  );

endmodule
